i2c_reg_ctrl: RTL and testbench

Register-map controller that sits downstream of the I2C slave and sequences its byte-level datapath. Master write transactions carry a pointer byte followed by data bytes, which land in an internal register file with auto-increment. Master reads stream register contents from the pointer onward by keeping the slave's transmit shifter primed one byte ahead. The top address is a read-only status port fed by the rest of the chip.

---
 rtl/i2c_reg_ctrl.sv | 106 ++++++++++
 tb/tb_i2c_reg_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_ctrl.sv
// Purpose: register-map controller behind an I2C slave; pointer+data writes with auto-increment, prefetching read stream.
// Latency: rx_valid -> register/wr_strobe/ptr update next cycle; tx_ready -> tx_load pulse next cycle.
// Backpressure: tx_load only fires when the slave reports tx_ready, the previous cycle had no load and no master write is active.
//
// Ports:
//   clock, reset          system clock, async active-high reset
//   rx_data/rx_valid      received byte and its one-cycle store strobe
//   rx_active             high while the master is writing to us
//   tx_ready              slave transmit shifter empty and idle
//   tx_data/tx_load       byte offered to the slave and its load strobe
//   status_in             live status byte, readable at address NUM_REGS-1
//   regs_q                flattened register file, reg i at [8i+7:8i]
//   wr_strobe/wr_addr     pulse + address for each master register write
//   ptr                   current register pointer (debug)
module i2c_reg_ctrl #(
    parameter int NUM_REGS = 16,
    localparam int AW = $clog2(NUM_REGS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  rx_active,
    input  logic                  tx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_load,
    input  logic [7:0]            status_in,
    output logic [NUM_REGS*8-1:0] regs_q,
    output logic                  wr_strobe,
    output logic [AW-1:0]         wr_addr,
    output logic [AW-1:0]         ptr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PTR   = 2'd1,
        WDATA = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);

    state_t     state;
    logic [7:0] regs [NUM_REGS];

    // Top address is the read-only status port; its storage entry is never written.
    assign tx_data = (ptr == LAST) ? status_in : regs[ptr];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_q[g*8 +: 8] = regs[g];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            tx_load   <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            wr_strobe <= 1'b0;

            // Gating on rx_active ignores a stale tx_ready while the master writes,
            // which also keeps loads and pointer writes from ever colliding.
            tx_load <= tx_ready && !tx_load && !rx_active;

            // The byte on tx_data has just been handed to the slave; move on.
            if (tx_load) begin
                ptr <= ptr + AW'(1);
            end

            case (state)
                IDLE: begin
                    if (rx_active) begin
                        state <= PTR;
                    end
                end
                PTR: begin
                    if (rx_valid) begin
                        ptr   <= rx_data[AW-1:0];
                        state <= rx_active ? WDATA : IDLE;
                    end else if (!rx_active) begin
                        state <= IDLE;
                    end
                end
                WDATA: begin
                    if (rx_valid) begin
                        if (ptr != LAST) begin
                            regs[ptr] <= rx_data;
                            wr_strobe <= 1'b1;
                            wr_addr   <= ptr;
                        end
                        ptr <= ptr + AW'(1);
                    end
                    if (!rx_active) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Purpose: self-checking bench for i2c_reg_ctrl with a reference register model and scoreboards.
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: bench acts as the slave, pulsing tx_ready once per byte and waiting for the load.
module tb_i2c_reg_ctrl;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_valid = 1'b0;
    logic         rx_active = 1'b0;
    logic         tx_ready = 1'b0;
    logic [7:0]   tx_data;
    logic         tx_load;
    logic [7:0]   status_in = 8'hC3;
    logic [127:0] regs_q;
    logic         wr_strobe;
    logic [3:0]   wr_addr;
    logic [3:0]   ptr;

    i2c_reg_ctrl #(.NUM_REGS(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_active (rx_active),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_load   (tx_load),
        .status_in (status_in),
        .regs_q    (regs_q),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .ptr       (ptr)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int load_cnt = 0;

    // Reference model
    logic [7:0] mregs [16];
    logic [3:0] mptr;

    // Scoreboards: expected tx bytes and expected {addr, data} writes
    logic [7:0]  txq [$];
    logic [11:0] wq  [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] reg_byte(input int idx);
        logic [127:0] v;
        v = regs_q;
        return v[idx*8 +: 8];
    endfunction

    // Output monitor
    logic prev_load = 1'b0;
    always @(negedge clock) begin
        if (tx_load) begin
            load_cnt++;
            check("tx_load_back_to_back", {31'd0, prev_load}, 32'd0);
            if (txq.size() > 0) begin
                logic [7:0] e;
                e = txq.pop_front();
                check("tx_data", {24'd0, tx_data}, {24'd0, e});
            end else begin
                check("tx_load_unexpected", 32'd1, 32'd0);
            end
        end
        if (wr_strobe) begin
            if (wq.size() > 0) begin
                logic [11:0] w;
                w = wq.pop_front();
                check("wr_addr", {28'd0, wr_addr}, {28'd0, w[11:8]});
                check("wr_data", {24'd0, reg_byte(int'(wr_addr))}, {24'd0, w[7:0]});
            end else begin
                check("wr_strobe_unexpected", 32'd1, 32'd0);
            end
        end
        prev_load = tx_load;
    end

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
        mptr = 4'd0;
    endtask

    // Master write: pointer byte p followed by n (0..3) data bytes
    task automatic write_txn(input logic [7:0] p, input int n,
                             input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        logic [7:0] d [3];
        d[0] = d0; d[1] = d1; d[2] = d2;
        rx_active = 1'b1;
        tick();
        rx_data = p; rx_valid = 1'b1;
        mptr = p[3:0];
        tick();
        rx_valid = 1'b0;
        tick();
        for (int i = 0; i < n; i++) begin
            rx_data = d[i]; rx_valid = 1'b1;
            if (mptr != 4'hF) begin
                wq.push_back({mptr, d[i]});
                mregs[mptr] = d[i];
            end
            mptr = mptr + 4'd1;
            tick();
            rx_valid = 1'b0;
            tick();
        end
        rx_active = 1'b0;
        tick();
        tick();
    endtask

    // Master read of n bytes: one tx_ready window per byte
    task automatic read_n(input int n);
        for (int i = 0; i < n; i++) begin
            int c;
            txq.push_back(mptr == 4'hF ? status_in : mregs[mptr]);
            mptr = mptr + 4'd1;
            c = load_cnt;
            tx_ready = 1'b1;
            tick();
            tx_ready = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (load_cnt != c) break;
                tick();
            end
            check("load_seen", {31'd0, load_cnt != c}, 32'd1);
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        model_reset();

        // Reset state
        tick();
        tick();
        check("rst_tx_load", {31'd0, tx_load}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
        check("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
        check("rst_ptr", {28'd0, ptr}, 32'd0);
        check("rst_regs", {31'd0, regs_q == 128'd0}, 32'd1);
        reset = 1'b0;
        tick();

        // Fill reg0..2, rewind pointer, stream them back
        write_txn(8'h00, 3, 8'h11, 8'h22, 8'h33);
        check("fill_ptr", {28'd0, ptr}, {28'd0, mptr});
        write_txn(8'h00, 0, 8'h00, 8'h00, 8'h00);
        check("rewind_ptr", {28'd0, ptr}, 32'd0);
        read_n(3);
        check("read3_ptr", {28'd0, ptr}, 32'd3);

        // Pointer + data write
        write_txn(8'h03, 2, 8'hAA, 8'hBB, 8'h00);
        check("reg3", {24'd0, reg_byte(3)}, 32'hAA);
        check("reg4", {24'd0, reg_byte(4)}, 32'hBB);
        check("ptr_after_w", {28'd0, ptr}, 32'd5);

        // Upper pointer bits ignored
        write_txn(8'hE7, 2, 8'h99, 8'h5C, 8'h00);
        check("reg7", {24'd0, reg_byte(7)}, 32'h99);
        check("reg8", {24'd0, reg_byte(8)}, 32'h5C);
        check("ptr_upper_ign", {28'd0, ptr}, 32'd9);

        // Wrap through the read-only address
        write_txn(8'h0F, 2, 8'h55, 8'h66, 8'h00);
        check("reg15_ro", {24'd0, reg_byte(15)}, 32'h00);
        check("reg0_wrap", {24'd0, reg_byte(0)}, 32'h66);
        check("ptr_wrap_w", {28'd0, ptr}, 32'd1);

        // Status read at the top address, pointer wraps to 0
        write_txn(8'h0F, 0, 8'h00, 8'h00, 8'h00);
        status_in = 8'h5A;
        read_n(1);
        check("ptr_wrap_r", {28'd0, ptr}, 32'd0);
        status_in = 8'hC3;

        // Queued-byte rule: reg1 loaded, then pointer moved to 8
        write_txn(8'h01, 0, 8'h00, 8'h00, 8'h00);
        read_n(1);
        write_txn(8'h08, 0, 8'h00, 8'h00, 8'h00);
        check("ptr_repoint", {28'd0, ptr}, 32'd8);
        read_n(1);
        check("ptr_after_q", {28'd0, ptr}, 32'd9);

        // Stale tx_ready during a master write never loads
        c = load_cnt;
        rx_active = 1'b1;
        tx_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        rx_active = 1'b0;
        tx_ready = 1'b0;
        tick();
        tick();
        check("no_load_rx_active", load_cnt, c);

        // Reset mid-WDATA, asserted while a data byte is being presented
        rx_active = 1'b1;
        tick();
        rx_data = 8'h05; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
        rx_data = 8'h77; rx_valid = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_ptr", {28'd0, ptr}, 32'd0);
        check("mid_rst_regs", {31'd0, regs_q == 128'd0}, 32'd1);
        check("mid_rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
        check("mid_rst_wr_addr", {28'd0, wr_addr}, 32'd0);
        check("mid_rst_tx_load", {31'd0, tx_load}, 32'd0);
        check("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
        rx_valid = 1'b0;
        rx_active = 1'b0;
        tick();
        reset = 1'b0;
        model_reset();
        tick();
        read_n(1);
        check("post_rst_ptr", {28'd0, ptr}, 32'd1);

        tick();
        tick();
        check("txq_drained", txq.size(), 0);
        check("wq_drained", wq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
